// File: rtl/bcd_timer.sv
// Prescaled BCD up/down timer with load/start/pause control and a sticky
// expired flag. The count advances one BCD step every TICK_DIV clocks while running.
module bcd_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                mode,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                expired,
  output logic                tick
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [W-1:0]  clamped, stepped, nines;
  logic [DIGITS:0] cy;
  logic          term_cur, term_nxt, pause_req, adv;

  assign nines = {DIGITS{4'h9}};
  assign cy[0] = 1'b1;

  // Ripple borrow/carry chain: a digit only moves when every lower digit wrapped.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] d, ld;
    assign d  = count[4*g +: 4];
    assign ld = load_val[4*g +: 4];
    assign clamped[4*g +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    assign cy[g+1] = cy[g] & (mode ? (d == 4'd9) : (d == 4'd0));
    assign stepped[4*g +: 4] = !cy[g] ? d :
                               mode   ? ((d == 4'd9) ? 4'd0 : d + 4'd1)
                                      : ((d == 4'd0) ? 4'd9 : d - 4'd1);
  end

  assign term_cur  = mode ? (count == nines)   : (count == '0);
  assign term_nxt  = mode ? (stepped == nines) : (stepped == '0);
  assign pause_req = pause & ~start;
  // An already-terminal value (e.g. after a mode flip) finishes without stepping.
  assign adv  = (state == RUN) & ~load & ~pause_req & (presc == PMAX) & ~term_cur;
  assign tick = adv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      count   <= '0;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else if (load) begin
      state   <= IDLE;
      count   <= clamped;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      case (state)
        IDLE, PAUSE: if (start) begin
          if (state == IDLE) presc <= '0;
          if (term_cur) begin
            state   <= DONE;
            expired <= 1'b1;
          end else begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (pause_req) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (presc == PMAX) begin
            presc <= '0;
            if (term_cur || term_nxt) begin
              state   <= DONE;
              running <= 1'b0;
              expired <= 1'b1;
            end
            if (!term_cur) count <= stepped;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_timer.sv
// Randomized + directed bench for bcd_timer; an integer-valued reference model
// queues expected ticks and a monitor checks them against the DUT.
module tb_bcd_timer;
  localparam int D = 4, TD = 4, W = 16, MAXV = 9999;

  logic clk = 0, rstn = 0, load = 0, start = 0, pause = 0, mode = 0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic running, expired, tick;

  bcd_timer #(.DIGITS(D), .TICK_DIV(TD)) dut (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .mode(mode), .count(count), .running(running),
    .expired(expired), .tick(tick));

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; } tick_rec_t;
  tick_rec_t exp_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, tick_cnt = 0;
  int m_val = 0, m_st = 0, m_presc = 0;  // m_st: 0 idle, 1 run, 2 pause, 3 done
  bit m_exp = 0, rst_flag = 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_int(logic [W-1:0] lv);
    int v = 0, p = 1, dg;
    for (int i = 0; i < D; i++) begin
      dg = int'(lv[4*i +: 4]);
      if (dg > 9) dg = 9;
      v += dg * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic bit at_term(int v, bit md);
    return md ? (v == MAXV) : (v == 0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rstn) rst_flag = 1;

  // Reference model: checks the state reached at the last edge, then predicts the next.
  always @(negedge clk) begin
    if (!rstn || rst_flag) begin
      rst_flag = 0; m_val = 0; m_st = 0; m_presc = 0; m_exp = 0;
      exp_q.delete();
    end
    chk("count", count, to_bcd(m_val));
    chk("running", running, m_st == 1);
    chk("expired", expired, m_exp);
    if (rstn) begin
      if (load) begin
        m_val = load_int(load_val); m_st = 0; m_exp = 0; m_presc = 0;
      end else if ((m_st == 0 || m_st == 2) && start) begin
        if (m_st == 0) m_presc = 0;
        if (at_term(m_val, mode)) begin m_st = 3; m_exp = 1; end
        else m_st = 1;
      end else if (m_st == 1) begin
        if (pause && !start) m_st = 2;
        else if (m_presc == TD - 1) begin
          m_presc = 0;
          if (at_term(m_val, mode)) begin m_st = 3; m_exp = 1; end
          else begin
            exp_q.push_back('{cyc, m_val});
            m_val = mode ? m_val + 1 : m_val - 1;
            if (at_term(m_val, mode)) begin m_st = 3; m_exp = 1; end
          end
        end else m_presc++;
      end
    end
  end

  // Monitor: every cycle, tick must match the head of the expected-tick queue.
  always @(negedge clk) begin
    tick_rec_t r;
    #1;
    if (tick === 1'b1) tick_cnt++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      r = exp_q.pop_front();
      chk("tick_expected", tick, 1);
      chk("tick_count_pre", count, to_bcd(r.val));
    end else begin
      chk("tick_unexpected", tick, 0);
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(bit l, bit s, bit p, logic [W-1:0] lv);
    load = l; start = s; pause = p;
    if (l) load_val = lv;
    @(posedge clk); #1;
    load = 0; start = 0; pause = 0;
  endtask

  initial begin
    int tc;
    #2;
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_expired", expired, 0);
    chk("rst_tick", tick, 0);
    #20 rstn = 1;
    @(posedge clk); #1;

    // Count down 3 -> 0: three ticks, expired at the end.
    mode = 0;
    cmd(1, 0, 0, 16'h0003);
    tc = tick_cnt;
    cmd(0, 1, 0, '0);
    idle(4);
    chk("s1_first_step", count, 16'h0002);
    idle(12);
    chk("s1_final", count, 16'h0000);
    chk("s1_expired", expired, 1);
    chk("s1_ticks", tick_cnt - tc, 3);

    // Cascaded borrow.
    cmd(1, 0, 0, 16'h1000);
    cmd(0, 1, 0, '0);
    idle(4);
    chk("s2_borrow", count, 16'h0999);

    // Count up to all-nines and hold.
    mode = 1;
    cmd(1, 0, 0, 16'h9998);
    cmd(0, 1, 0, '0);
    idle(4);
    chk("s3_nines", count, 16'h9999);
    chk("s3_expired", expired, 1);
    idle(20);
    chk("s3_hold", count, 16'h9999);

    // Pause keeps the prescaler; resume continues from it.
    mode = 0;
    cmd(1, 0, 0, 16'h0050);
    cmd(0, 1, 0, '0);
    idle(1);
    tc = tick_cnt;
    cmd(0, 0, 1, '0);
    idle(10);
    chk("s4_no_tick_paused", tick_cnt, tc);
    cmd(0, 1, 0, '0);
    idle(2);
    chk("s4_before_tick", count, 16'h0050);
    idle(1);
    chk("s4_after_tick", count, 16'h0049);

    // Load beats start; out-of-range digit clamps.
    cmd(1, 1, 0, 16'h00A5);
    chk("s5_count", count, 16'h0095);
    chk("s5_running", running, 0);
    chk("s5_expired", expired, 0);

    // Asynchronous reset mid-run, then start from zero finishes at once.
    cmd(1, 0, 0, 16'h0042);
    cmd(0, 1, 0, '0);
    idle(6);
    rstn = 0;
    #1;
    chk("s6_rst_count", count, 0);
    chk("s6_rst_running", running, 0);
    chk("s6_rst_expired", expired, 0);
    chk("s6_rst_tick", tick, 0);
    #1 rstn = 1;
    cmd(0, 1, 0, '0);
    chk("s6_done_expired", expired, 1);
    chk("s6_done_running", running, 0);

    // Random command traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      load  = ($urandom % 25) == 0;
      start = ($urandom % 5) == 0;
      pause = ($urandom % 8) == 0;
      if (($urandom % 40) == 0) mode = ~mode;
      if (load) begin
        case ($urandom % 3)
          0: load_val = 16'($urandom);
          1: load_val = 16'h0000 | 16'($urandom_range(0, 3));
          default: load_val = 16'h9999 - 16'($urandom_range(0, 3));
        endcase
      end
      @(posedge clk); #1;
      load = 0; start = 0; pause = 0;
    end

    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
